// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder between fetch and a word-wide backing memory.
// Defining IMEM_TIMEOUT_EN adds a BUSY watchdog that aborts a stalled memory read.
module imem_responder #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        IF_CLK,
    input  logic        IF_RESET,
    input  logic [31:0] ADDR,
    input  logic        ADDR_VALID,
    input  logic        FLUSH,
    output logic [29:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    output logic        PC_WRITE,
    output logic        MISALIGN,
    output logic        TIMEOUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [29:0] mem_addr_r;
    logic [29:0] mem_addr_s;
    logic        mem_rd_r;
    logic        mem_rd_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic        instr_valid_r;
    logic        instr_valid_s;
    logic        pc_write_r;
    logic        pc_write_s;
    logic        misalign_r;
    logic        misalign_s;
    logic        drop_r;
    logic        drop_s;
    logic        drop_any_s;
    logic        tmo_hit_s;

`ifdef IMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_r;
    logic       timeout_r;

    assign tmo_hit_s = (cnt_r == TMO_LAST);

    // Watchdog: counter sits at zero outside BUSY, so every BUSY entry starts a fresh count
    always_ff @(posedge IF_CLK) begin
        if (IF_RESET) begin
            cnt_r     <= 8'd0;
            timeout_r <= 1'b0;
        end else if (state_r != ST_BUSY) begin
            cnt_r     <= 8'd0;
        end else if (!MEM_READY && tmo_hit_s) begin
            timeout_r <= 1'b1;
        end else begin
            cnt_r     <= cnt_r + 8'd1;
        end
    end

    assign TIMEOUT = timeout_r;
`else
    assign tmo_hit_s = 1'b0;
    assign TIMEOUT   = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/BUSY/DONE fetch sequence
    always_comb begin
        state_s       = state_r;
        mem_addr_s    = mem_addr_r;
        mem_rd_s      = mem_rd_r;
        instr_s       = instr_r;
        instr_valid_s = 1'b0;
        pc_write_s    = 1'b0;
        misalign_s    = misalign_r;
        drop_s        = drop_r;
        drop_any_s    = drop_r | FLUSH;
        case (state_r)
            ST_IDLE: begin
                mem_rd_s = 1'b0;
                drop_s   = 1'b0;
                if (ADDR_VALID) begin
                    if (ADDR[1:0] == 2'b00) begin
                        mem_addr_s = ADDR[31:2];
                        mem_rd_s   = 1'b1;
                        state_s    = ST_BUSY;
                    end else begin
                        misalign_s    = 1'b1;
                        instr_s       = NOP_INSTR;
                        instr_valid_s = 1'b1;
                        pc_write_s    = 1'b1;
                        state_s       = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A flush never cancels the memory read; it only poisons the returned word
                drop_s = drop_any_s;
                if (MEM_READY) begin
                    instr_s       = drop_any_s ? NOP_INSTR : MEM_RDATA;
                    mem_rd_s      = 1'b0;
                    instr_valid_s = 1'b1;
                    pc_write_s    = 1'b1;
                    state_s       = ST_DONE;
                end else if (tmo_hit_s) begin
                    instr_s       = NOP_INSTR;
                    mem_rd_s      = 1'b0;
                    instr_valid_s = 1'b1;
                    pc_write_s    = 1'b1;
                    state_s       = ST_DONE;
                end else begin
                    mem_rd_s = 1'b1;
                    state_s  = ST_BUSY;
                end
            end
            ST_DONE: begin
                mem_rd_s = 1'b0;
                drop_s   = 1'b0;
                state_s  = ST_IDLE;
            end
            default: begin
                mem_rd_s = 1'b0;
                drop_s   = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge IF_CLK) begin
        if (IF_RESET) begin
            state_r       <= ST_IDLE;
            mem_addr_r    <= 30'd0;
            mem_rd_r      <= 1'b0;
            instr_r       <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            pc_write_r    <= 1'b0;
            misalign_r    <= 1'b0;
            drop_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            mem_addr_r    <= mem_addr_s;
            mem_rd_r      <= mem_rd_s;
            instr_r       <= instr_s;
            instr_valid_r <= instr_valid_s;
            pc_write_r    <= pc_write_s;
            misalign_r    <= misalign_s;
            drop_r        <= drop_s;
        end
    end

    assign MEM_ADDR    = mem_addr_r;
    assign MEM_RD      = mem_rd_r;
    assign INSTR_VALID = instr_valid_r;
    assign PC_WRITE    = pc_write_r;
    assign MISALIGN    = misalign_r;
    // A redirect during the delivery cycle must squash the word decode is about to take
    assign INSTR       = ((state_r == ST_DONE) && FLUSH) ? NOP_INSTR : instr_r;

endmodule
